// File: rtl/ray_tracer_pkg.sv
// rtl/ray_tracer_pkg.sv - shared widths, fixed-point format and FSM encoding for triangle setup
package ray_tracer_pkg;

  localparam int QM   = 23;
  localparam int QF   = 23;
  localparam int QW   = QM + QF;
  localparam int DW   = QW + 1;

  localparam int VX_W = 10;
  localparam int VY_W = 9;
  localparam int VZ_W = 3;
  localparam int EX_W = 11;
  localparam int EY_W = 10;
  localparam int EZ_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_DIVIDE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Clamp a raw quotient magnitude to the largest positive Q23.23 value.
  function automatic logic [QW-1:0] sat_mag(input logic [DW-1:0] q);
    if (q[DW-1] || q[DW-2]) begin
      return {1'b0, {(QW-1){1'b1}}};
    end
    return q[QW-1:0];
  endfunction

endpackage

// File: rtl/tt_um_emern_recip_div.sv
// rtl/tt_um_emern_recip_div.sv - serial restoring divider computing 2^(QM+QF) / divisor
// One quotient bit per cycle, MSB first; o_done flags the final step with the full quotient.
module tt_um_emern_recip_div
  import ray_tracer_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic [DW-1:0] i_divisor,
  output logic          o_busy,
  output logic          o_done,
  output logic [DW-1:0] o_quotient
);

  logic [DW-1:0] r_rem;
  logic [DW-1:0] r_div;
  logic [DW-2:0] r_quo;
  logic [5:0]    r_cnt;
  logic          r_busy;

  logic          w_bit;
  logic [DW:0]   w_rem_sh;
  logic [DW:0]   w_diff;
  logic          w_qbit;

  // The dividend is a single 1 in its MSB, so only the first step shifts in a 1.
  assign w_bit    = (r_cnt == 6'(DW-1));
  assign w_rem_sh = {r_rem, w_bit};
  assign w_diff   = w_rem_sh - {1'b0, r_div};
  assign w_qbit   = ~w_diff[DW];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_div  <= '0;
      r_quo  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start && !r_busy) begin
      r_div  <= i_divisor;
      r_rem  <= '0;
      r_quo  <= '0;
      r_cnt  <= 6'(DW-1);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem <= w_qbit ? w_diff[DW-1:0] : w_rem_sh[DW-1:0];
      r_quo <= {r_quo[DW-3:0], w_qbit};
      r_cnt <= r_cnt - 6'd1;
      if (r_cnt == 6'd0) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_busy && (r_cnt == 6'd0);
  assign o_quotient = {r_quo, w_qbit};

endmodule

// File: rtl/tt_um_emern_triangle_setup.sv
// rtl/tt_um_emern_triangle_setup.sv - triangle edge/determinant/reciprocal setup stage
// Optional BACKFACE_CULL_EN: negative-determinant triangles are culled instead of divided.
module tt_um_emern_triangle_setup
  import ray_tracer_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [VX_W-1:0] v0_x,
  input  logic [VX_W-1:0] v1_x,
  input  logic [VX_W-1:0] v2_x,
  input  logic [VY_W-1:0] v0_y,
  input  logic [VY_W-1:0] v1_y,
  input  logic [VY_W-1:0] v2_y,
  input  logic [VZ_W-1:0] v0_z,
  input  logic [VZ_W-1:0] v1_z,
  input  logic [VZ_W-1:0] v2_z,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [EX_W-1:0] edge_1_x,
  output logic [EY_W-1:0] edge_1_y,
  output logic [EZ_W-1:0] edge_1_z,
  output logic [EX_W-1:0] edge_2_x,
  output logic [EY_W-1:0] edge_2_y,
  output logic [EZ_W-1:0] edge_2_z,
  output logic [VX_W-1:0] vertex_0_x,
  output logic [VY_W-1:0] vertex_0_y,
  output logic [VZ_W-1:0] vertex_0_z,
  output logic [QM-1:0]   determinant,
  output logic [QW-1:0]   inv_det,
  output logic            degenerate,
  output logic            culled
);

  state_t          r_state;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [VX_W-1:0] r_v0_x, r_v1_x, r_v2_x;
  logic [VY_W-1:0] r_v0_y, r_v1_y, r_v2_y;
  logic [VZ_W-1:0] r_v0_z, r_v1_z, r_v2_z;
  logic [EX_W-1:0] r_e1_x, r_e2_x;
  logic [EY_W-1:0] r_e1_y, r_e2_y;
  logic [EZ_W-1:0] r_e1_z, r_e2_z;
  logic [QM-1:0]   r_det;
  logic [QW-1:0]   r_inv;
  logic            r_degen;
`ifdef BACKFACE_CULL_EN
  logic            r_culled;
`endif

  logic [EX_W-1:0] w_e1_x, w_e2_x;
  logic [EY_W-1:0] w_e1_y, w_e2_y;
  logic [EZ_W-1:0] w_e1_z, w_e2_z;
  logic [21:0]     w_p1, w_p2, w_pdiff;
  logic [QM-1:0]   w_det, w_det_abs;
  logic            w_cull_now;
  logic            w_div_start, w_div_busy, w_div_done;
  logic [DW-1:0]   w_quotient;
  logic [QW-1:0]   w_mag, w_inv;

  assign w_e1_x = {1'b0, r_v1_x} - {1'b0, r_v0_x};
  assign w_e1_y = {1'b0, r_v1_y} - {1'b0, r_v0_y};
  assign w_e1_z = {1'b0, r_v1_z} - {1'b0, r_v0_z};
  assign w_e2_x = {1'b0, r_v2_x} - {1'b0, r_v0_x};
  assign w_e2_y = {1'b0, r_v2_y} - {1'b0, r_v0_y};
  assign w_e2_z = {1'b0, r_v2_z} - {1'b0, r_v0_z};

  // Operands are sign-extended to 22 bits so the truncated products stay exact two's complement.
  assign w_p1    = {{11{w_e1_x[EX_W-1]}}, w_e1_x} * {{12{w_e2_y[EY_W-1]}}, w_e2_y};
  assign w_p2    = {{12{w_e1_y[EY_W-1]}}, w_e1_y} * {{11{w_e2_x[EX_W-1]}}, w_e2_x};
  assign w_pdiff = w_p1 - w_p2;
  assign w_det   = {w_pdiff[21], w_pdiff};
  assign w_det_abs = w_det[QM-1] ? -w_det : w_det;

`ifdef BACKFACE_CULL_EN
  assign w_cull_now = w_det[QM-1];
`else
  assign w_cull_now = 1'b0;
`endif

  assign w_div_start = (r_state == ST_SETUP) && (w_det != '0) && !w_cull_now && !w_div_busy;

  tt_um_emern_recip_div u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_div_start),
    .i_divisor  ({{(DW-QM){1'b0}}, w_det_abs}),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quotient (w_quotient)
  );

  assign w_mag = sat_mag(w_quotient);
  assign w_inv = r_det[QM-1] ? -w_mag : w_mag;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_v0_x <= '0; r_v1_x <= '0; r_v2_x <= '0;
      r_v0_y <= '0; r_v1_y <= '0; r_v2_y <= '0;
      r_v0_z <= '0; r_v1_z <= '0; r_v2_z <= '0;
      r_e1_x <= '0; r_e1_y <= '0; r_e1_z <= '0;
      r_e2_x <= '0; r_e2_y <= '0; r_e2_z <= '0;
      r_det   <= '0;
      r_inv   <= '0;
      r_degen <= 1'b0;
`ifdef BACKFACE_CULL_EN
      r_culled <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_v0_x <= v0_x; r_v1_x <= v1_x; r_v2_x <= v2_x;
            r_v0_y <= v0_y; r_v1_y <= v1_y; r_v2_y <= v2_y;
            r_v0_z <= v0_z; r_v1_z <= v1_z; r_v2_z <= v2_z;
            r_in_ready <= 1'b0;
            r_state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_e1_x <= w_e1_x; r_e1_y <= w_e1_y; r_e1_z <= w_e1_z;
          r_e2_x <= w_e2_x; r_e2_y <= w_e2_y; r_e2_z <= w_e2_z;
          r_det   <= w_det;
          r_inv   <= '0;
          r_degen <= (w_det == '0);
`ifdef BACKFACE_CULL_EN
          r_culled <= w_cull_now && (w_det != '0);
`endif
          if ((w_det == '0) || w_cull_now) begin
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_state <= ST_DIVIDE;
          end
        end
        ST_DIVIDE: begin
          if (w_div_done) begin
            r_inv       <= w_inv;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign edge_1_x    = r_e1_x;
  assign edge_1_y    = r_e1_y;
  assign edge_1_z    = r_e1_z;
  assign edge_2_x    = r_e2_x;
  assign edge_2_y    = r_e2_y;
  assign edge_2_z    = r_e2_z;
  assign vertex_0_x  = r_v0_x;
  assign vertex_0_y  = r_v0_y;
  assign vertex_0_z  = r_v0_z;
  assign determinant = r_det;
  assign inv_det     = r_inv;
  assign degenerate  = r_degen;
`ifdef BACKFACE_CULL_EN
  assign culled      = r_culled;
`else
  assign culled      = 1'b0;
`endif

endmodule

// File: tb/tb_tt_um_emern_triangle_setup.sv
// tb/tb_tt_um_emern_triangle_setup.sv - scoreboard bench for the triangle setup stage
module tb_tt_um_emern_triangle_setup;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, degenerate, culled;
  logic [9:0]  v0_x = '0, v1_x = '0, v2_x = '0;
  logic [8:0]  v0_y = '0, v1_y = '0, v2_y = '0;
  logic [2:0]  v0_z = '0, v1_z = '0, v2_z = '0;
  logic [10:0] edge_1_x, edge_2_x;
  logic [9:0]  edge_1_y, edge_2_y;
  logic [3:0]  edge_1_z, edge_2_z;
  logic [9:0]  vertex_0_x;
  logic [8:0]  vertex_0_y;
  logic [2:0]  vertex_0_z;
  logic [22:0] determinant;
  logic [45:0] inv_det;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    longint e1x, e1y, e1z, e2x, e2y, e2z;
    longint v0x, v0y, v0z;
    longint det, inv;
    longint degen, cull;
    int     lat;
  } exp_t;

  exp_t sb[$];

  tt_um_emern_triangle_setup dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .v0_x(v0_x), .v1_x(v1_x), .v2_x(v2_x),
    .v0_y(v0_y), .v1_y(v1_y), .v2_y(v2_y),
    .v0_z(v0_z), .v1_z(v1_z), .v2_z(v2_z),
    .out_valid(out_valid), .out_ready(out_ready),
    .edge_1_x(edge_1_x), .edge_1_y(edge_1_y), .edge_1_z(edge_1_z),
    .edge_2_x(edge_2_x), .edge_2_y(edge_2_y), .edge_2_z(edge_2_z),
    .vertex_0_x(vertex_0_x), .vertex_0_y(vertex_0_y), .vertex_0_z(vertex_0_z),
    .determinant(determinant), .inv_det(inv_det),
    .degenerate(degenerate), .culled(culled)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input int x0, y0, z0, x1, y1, z1, x2, y2, z2);
    exp_t   e;
    longint mag, q;
    e.v0x = x0; e.v0y = y0; e.v0z = z0;
    e.e1x = x1 - x0; e.e1y = y1 - y0; e.e1z = z1 - z0;
    e.e2x = x2 - x0; e.e2y = y2 - y0; e.e2z = z2 - z0;
    e.det = e.e1x * e.e2y - e.e1y * e.e2x;
    e.inv = 0; e.degen = 0; e.cull = 0; e.lat = 48;
    if (e.det == 0) begin
      e.degen = 1; e.lat = 1;
    end else begin
`ifdef BACKFACE_CULL_EN
      if (e.det < 0) begin
        e.cull = 1; e.lat = 1;
      end
`endif
      if (e.cull == 0) begin
        mag = (e.det < 0) ? -e.det : e.det;
        q = (longint'(1) << 46) / mag;
        if (q >= (longint'(1) << 45)) q = (longint'(1) << 45) - 1;
        e.inv = (e.det < 0) ? -q : q;
      end
    end
    return e;
  endfunction

  task automatic cmp_out(input exp_t g);
    chk("e1x", $signed(edge_1_x), g.e1x);
    chk("e1y", $signed(edge_1_y), g.e1y);
    chk("e1z", $signed(edge_1_z), g.e1z);
    chk("e2x", $signed(edge_2_x), g.e2x);
    chk("e2y", $signed(edge_2_y), g.e2y);
    chk("e2z", $signed(edge_2_z), g.e2z);
    chk("v0x", longint'(vertex_0_x), g.v0x);
    chk("v0y", longint'(vertex_0_y), g.v0y);
    chk("v0z", longint'(vertex_0_z), g.v0z);
    chk("det", $signed(determinant), g.det);
    chk("inv_det", $signed(inv_det), g.inv);
    chk("degenerate", longint'(degenerate), g.degen);
    chk("culled", longint'(culled), g.cull);
  endtask

  task automatic apply(input int x0, y0, z0, x1, y1, z1, x2, y2, z2,
                       input int hold, input bit do_reset);
    exp_t e, g;
    int   n;
    e = model(x0, y0, z0, x1, y1, z1, x2, y2, z2);
    sb.push_back(e);
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_wait", longint'(in_ready), 1);
    v0_x = 10'(x0); v0_y = 9'(y0); v0_z = 3'(z0);
    v1_x = 10'(x1); v1_y = 9'(y1); v1_z = 3'(z1);
    v2_x = 10'(x2); v2_y = 9'(y2); v2_z = 3'(z2);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    v0_x = 10'($urandom); v1_x = 10'($urandom); v2_x = 10'($urandom);
    v0_y = 9'($urandom);  v1_y = 9'($urandom);  v2_y = 9'($urandom);
    if (do_reset) begin
      repeat (20) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      g = sb.pop_front();
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_in_ready", longint'(in_ready), 1);
      chk("rst_inv_det", longint'(inv_det), 0);
      chk("rst_det", longint'(determinant), 0);
      chk("rst_e1x", longint'(edge_1_x), 0);
      chk("rst_v0x", longint'(vertex_0_x), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      return;
    end
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!out_valid && n < 100);
    chk("latency", n, e.lat);
    chk("out_valid", longint'(out_valid), 1);
    g = sb.pop_front();
    cmp_out(g);
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      v0_x = 10'($urandom); v1_y = 9'($urandom); v2_x = 10'($urandom);
      @(posedge clk); #1;
      chk("hold_in_ready", longint'(in_ready), 0);
      chk("hold_out_valid", longint'(out_valid), 1);
      chk("hold_inv_det", $signed(inv_det), g.inv);
      chk("hold_det", $signed(determinant), g.det);
      chk("hold_v0x", longint'(vertex_0_x), g.v0x);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_out_valid", longint'(out_valid), 0);
    chk("post_in_ready", longint'(in_ready), 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", longint'(in_ready), 1);
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_inv_det", longint'(inv_det), 0);
    chk("reset_det", longint'(determinant), 0);
    chk("reset_degenerate", longint'(degenerate), 0);
    chk("reset_culled", longint'(culled), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    apply(0, 0, 0, 10, 0, 1, 0, 10, 2, 0, 0);
    apply(0, 0, 0, 0, 10, 2, 10, 0, 1, 0, 0);
    apply(0, 0, 0, 10, 0, 1, 20, 0, 0, 0, 0);
    apply(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    apply(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    apply(5, 5, 1, 7, 5, 2, 5, 6, 3, 0, 0);
    apply(100, 50, 3, 900, 60, 4, 120, 500, 7, 10, 0);
    apply(0, 0, 0, 10, 0, 1, 0, 10, 2, 0, 1);
    apply(0, 0, 0, 10, 0, 1, 0, 10, 2, 0, 0);
    apply(0, 0, 0, 1023, 0, 7, 0, 511, 0, 2, 0);
    apply(1023, 511, 7, 0, 511, 0, 1023, 0, 0, 0, 0);
    for (int t = 0; t < 6; t++) begin
      apply($urandom_range(0, 1023), $urandom_range(0, 511), $urandom_range(0, 7),
            $urandom_range(0, 1023), $urandom_range(0, 511), $urandom_range(0, 7),
            $urandom_range(0, 1023), $urandom_range(0, 511), $urandom_range(0, 7),
            $urandom_range(0, 3), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
